// File: rtl/hazard_tracker.sv
// Hazard tracker for the 5-stage pipeline. It tracks E/M/W occupancy and drives stall and operand-forward selects.
// Define HAZARD_STATS_EN to add the saturating stall_cnt output.
module hazard_fwd_sel #(
  parameter int RA_W = 5
) (
  input  logic            use_src,
  input  logic [RA_W-1:0] src,
  input  logic            m_ok,
  input  logic [RA_W-1:0] m_dest,
  input  logic            w_ok,
  input  logic [RA_W-1:0] w_dest,
  output logic [1:0]      sel
);
  // src==0 short-circuits everything, so a dest of $0 can never forward.
  always_comb begin
    sel = 2'b00;
    if (use_src && src != '0) begin
      if (m_ok && m_dest == src)      sel = 2'b01;
      else if (w_ok && w_dest == src) sel = 2'b10;
    end
  end
endmodule

module hazard_tracker #(
  parameter int RA_W     = 5,
  parameter int LINK_REG = 31,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_d,
  input  logic [3:0]        type_d,
  input  logic              valid_d,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e
`ifdef HAZARD_STATS_EN
  ,output logic [STAT_W-1:0] stall_cnt
`endif
);
  localparam logic [3:0] T_R = 4'd1, T_IMM = 4'd2, T_BR = 4'd3, T_LD = 4'd4,
                         T_JR = 4'd5, T_JAL = 4'd6, T_ST = 4'd7;

  typedef struct packed {
    logic            valid;
    logic [3:0]      typ;
    logic [RA_W-1:0] dest;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
  } stage_t;

  stage_t e, m, w, d_ent;

  function automatic logic [RA_W-1:0] dest_of(input logic [31:0] ins, input logic [3:0] t);
    case (t)
      T_R:        dest_of = ins[11+:RA_W];
      T_IMM, T_LD: dest_of = ins[16+:RA_W];
      T_JAL:      dest_of = RA_W'(LINK_REG);
      default:    dest_of = '0;
    endcase
  endfunction

  function automatic logic uses_rs(input logic [3:0] t);
    uses_rs = (t == T_R) || (t == T_IMM) || (t == T_BR) || (t == T_LD) || (t == T_JR) || (t == T_ST);
  endfunction

  function automatic logic uses_rt(input logic [3:0] t);
    uses_rt = (t == T_R) || (t == T_BR) || (t == T_ST);
  endfunction

  function automatic logic src_hit(input logic [RA_W-1:0] dest, input logic [3:0] t,
                                   input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt);
    src_hit = (dest != '0) && ((uses_rs(t) && rs == dest) || (uses_rt(t) && rt == dest));
  endfunction

  always_comb begin
    d_ent       = '0;
    d_ent.valid = 1'b1;
    d_ent.typ   = type_d;
    d_ent.dest  = dest_of(instr_d, type_d);
    d_ent.rs    = instr_d[21+:RA_W];
    d_ent.rt    = instr_d[16+:RA_W];
  end

  // Branches and jr resolve in D, so any in-flight writer in E (or a load still in M) blocks them.
  logic d_early, e_hit, m_hit;
  assign d_early = (type_d == T_BR) || (type_d == T_JR);
  assign e_hit   = e.valid && src_hit(e.dest, type_d, d_ent.rs, d_ent.rt);
  assign m_hit   = m.valid && src_hit(m.dest, type_d, d_ent.rs, d_ent.rt);
  assign stall   = valid_d && ((e_hit && e.typ == T_LD) || (d_early && e_hit) ||
                               (d_early && m_hit && m.typ == T_LD));

  // Four select slots: D.rs, D.rt, E.rs, E.rt.
  logic                 m_ok, w_ok;
  logic [3:0]           use_v;
  logic [3:0][RA_W-1:0] src_v;
  logic [3:0][1:0]      sel_v;

  assign m_ok  = m.valid && m.typ != T_LD;
  assign w_ok  = w.valid;
  assign use_v = {e.valid && uses_rt(e.typ), e.valid && uses_rs(e.typ), uses_rt(type_d), uses_rs(type_d)};
  assign src_v = {e.rt, e.rs, d_ent.rt, d_ent.rs};

  for (genvar g = 0; g < 4; g++) begin : g_fwd
    hazard_fwd_sel #(.RA_W(RA_W)) u_sel (
      .use_src (use_v[g]),
      .src     (src_v[g]),
      .m_ok    (m_ok),
      .m_dest  (m.dest),
      .w_ok    (w_ok),
      .w_dest  (w.dest),
      .sel     (sel_v[g])
    );
  end

  assign fwd_rs_d = sel_v[0];
  assign fwd_rt_d = sel_v[1];
  assign fwd_rs_e = sel_v[2];
  assign fwd_rt_e = sel_v[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      e <= '0;
      m <= '0;
      w <= '0;
    end else begin
      w <= m;
      m <= e;
      if (!stall && valid_d) e <= d_ent;
      else                   e.valid <= 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)                    stall_cnt <= '0;
    else if (stall && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule
